// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and the MEM stage.
// Latency: request cycle to done pulse is 6 (word read), 4 (half read), 3 (byte read), 5 (word write), 2 (byte write).
// Backpressure: rdy=0 freezes all state and masks ram_wr/done; requesters hold their request until done.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global freeze when 0)
//   if_req/if_addr/if_flush -> if_done/if_inst      : instruction fetch, always a 32-bit word
//   ma_re/ma_we/ma_width/ma_addr/ma_wdata -> ma_done/ma_rdata : loads/stores of byte/half/word
//   ram_din <- RAM read byte (valid the rdy cycle after its address)
//   ram_a/ram_dout/ram_wr -> RAM byte port
//   if_stall_req/ma_stall_req -> pipeline stall bus
module mem_ctrl #(
    parameter int MEM_PRIORITY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  ma_re,
    input  logic                  ma_we,
    input  logic [2:0]            ma_width,
    input  logic [ADDR_WIDTH-1:0] ma_addr,
    input  logic [31:0]           ma_wdata,
    output logic                  ma_done,
    output logic [31:0]           ma_rdata,
    input  logic [7:0]            ram_din,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    output logic                  if_stall_req,
    output logic                  ma_stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic                  owner_ma;   // 1 = MEM stage owns the port, 0 = IF
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            n_m1;       // transfer length minus one (0, 1 or 3)
    logic [1:0]            cnt;
    logic                  is_wr;
    logic                  uns;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf;
    logic [ADDR_WIDTH-1:0] ram_a_q;
    logic [7:0]            ram_dout_q;
    logic                  ram_wr_q;
    logic [31:0]           if_inst_q;
    logic [31:0]           ma_rdata_q;

    // ------------------------------------------------------------------
    // Arbitration and request decode
    // ------------------------------------------------------------------
    logic       ma_req;
    logic       if_ok;
    logic       take_ma;
    logic       take_if;
    logic [1:0] ma_n_m1;

    assign ma_req = ma_re | ma_we;
    // A fetch raised together with a redirect is stale and must not start.
    assign if_ok  = if_req & ~if_flush;

    always_comb begin
        take_ma = 1'b0;
        if (ma_req) begin
            if (MEM_PRIORITY != 0) take_ma = 1'b1;
            else                   take_ma = ~if_ok;
        end
    end

    assign take_if = if_ok & ~take_ma;

    always_comb begin
        case (ma_width[1:0])
            2'b00:   ma_n_m1 = 2'd0;
            2'b01:   ma_n_m1 = 2'd1;
            default: ma_n_m1 = 2'd3;   // 10 and the reserved 11 both mean word
        endcase
    end

    // Flush only ever cancels an IF-owned transaction; IDLE never reaches here.
    logic flush_if;
    assign flush_if = if_flush & ~owner_ma;

    // ------------------------------------------------------------------
    // Byte counter helpers
    // ------------------------------------------------------------------
    logic [1:0] cnt_m1;
    logic [1:0] cnt_p1;
    assign cnt_m1 = cnt - 2'd1;
    assign cnt_p1 = cnt + 2'd1;

    // ------------------------------------------------------------------
    // Load extension from the fully assembled buffer (used in DONE)
    // ------------------------------------------------------------------
    logic [31:0] ld_ext;
    always_comb begin
        ld_ext = rbuf;
        case (n_m1)
            2'd0:    ld_ext = {{24{~uns & rbuf[7]}},  rbuf[7:0]};
            2'd1:    ld_ext = {{16{~uns & rbuf[15]}}, rbuf[15:0]};
            default: ld_ext = rbuf;
        endcase
    end

    // ------------------------------------------------------------------
    // Main FSM: all state and RAM-side outputs are registered here
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner_ma   <= 1'b0;
            base       <= '0;
            n_m1       <= 2'd0;
            cnt        <= 2'd0;
            is_wr      <= 1'b0;
            uns        <= 1'b0;
            wdata_q    <= '0;
            rbuf       <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_inst_q  <= '0;
            ma_rdata_q <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (take_ma || take_if) begin
                        owner_ma   <= take_ma;
                        base       <= take_ma ? ma_addr : if_addr;
                        n_m1       <= take_ma ? ma_n_m1 : 2'd3;
                        // re+we together is a store
                        is_wr      <= take_ma & ma_we;
                        uns        <= take_ma & ma_width[2];
                        wdata_q    <= ma_wdata;
                        cnt        <= 2'd0;
                        rbuf       <= '0;
                        // First byte address/data presented in the first ISSUE cycle
                        ram_a_q    <= take_ma ? ma_addr : if_addr;
                        ram_dout_q <= ma_wdata[7:0];
                        ram_wr_q   <= take_ma & ma_we;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (flush_if) begin
                        ram_a_q  <= '0;
                        ram_wr_q <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // RAM data lags its address by one cycle, so the byte
                        // arriving now belongs to the previous counter value.
                        if (!is_wr && cnt != 2'd0)
                            rbuf[{cnt_m1, 3'b000} +: 8] <= ram_din;
                        if (cnt == n_m1) begin
                            ram_a_q    <= '0;
                            ram_dout_q <= '0;
                            ram_wr_q   <= 1'b0;
                            state      <= is_wr ? DONE : LAST;
                        end else begin
                            cnt        <= cnt_p1;
                            ram_a_q    <= base + ADDR_WIDTH'(cnt_p1);
                            ram_dout_q <= wdata_q[{cnt_p1, 3'b000} +: 8];
                        end
                    end
                end

                LAST: begin
                    if (flush_if) begin
                        state <= IDLE;
                    end else begin
                        rbuf[{n_m1, 3'b000} +: 8] <= ram_din;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // Results are latched only on a real done so that a
                    // flushed fetch leaves if_inst untouched.
                    if (owner_ma && !is_wr)
                        ma_rdata_q <= ld_ext;
                    if (!owner_ma && !if_flush)
                        if_inst_q <= rbuf;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_done;
    assign in_done = rdy && (state == DONE);

    assign if_done  = in_done & ~owner_ma & ~if_flush;
    assign ma_done  = in_done &  owner_ma;

    // The done-cycle value is shown directly; the registered copy holds it afterwards.
    assign if_inst  = if_done ? rbuf : if_inst_q;
    assign ma_rdata = (ma_done && !is_wr) ? ld_ext : ma_rdata_q;

    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q & rdy;

    assign if_stall_req = if_req & ~if_done;
    assign ma_stall_req = (ma_re | ma_we) & ~ma_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte RAM model per instance.
// Latency: n/a (bench).
// Backpressure: drives rdy directly to exercise the freeze path.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        ma_re, ma_we;
    logic [2:0]  ma_width;
    logic [31:0] ma_addr, ma_wdata;
    logic        if_done, ma_done, ram_wr, if_stall_req, ma_stall_req;
    logic [31:0] if_inst, ma_rdata, ram_a;
    logic [7:0]  ram_din, ram_dout;

    // second instance, IF priority, read-only use
    logic        if_req0, ma_re0, ma_we0;
    logic        if_done0, ma_done0, ram_wr0, if_stall_req0, ma_stall_req0;
    logic [31:0] if_inst0, ma_rdata0, ram_a0;
    logic [7:0]  ram_din0, ram_dout0;

    mem_ctrl #(.MEM_PRIORITY(1), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_inst(if_inst),
        .ma_re(ma_re), .ma_we(ma_we), .ma_width(ma_width), .ma_addr(ma_addr),
        .ma_wdata(ma_wdata), .ma_done(ma_done), .ma_rdata(ma_rdata),
        .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .if_stall_req(if_stall_req), .ma_stall_req(ma_stall_req)
    );

    mem_ctrl #(.MEM_PRIORITY(0), .ADDR_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req0), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done0), .if_inst(if_inst0),
        .ma_re(ma_re0), .ma_we(ma_we0), .ma_width(ma_width), .ma_addr(ma_addr),
        .ma_wdata(ma_wdata), .ma_done(ma_done0), .ma_rdata(ma_rdata0),
        .ram_din(ram_din0), .ram_a(ram_a0), .ram_dout(ram_dout0), .ram_wr(ram_wr0),
        .if_stall_req(if_stall_req0), .ma_stall_req(ma_stall_req0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: registered read, gated by rdy like the real environment
    logic [7:0] mem1 [0:4095];
    logic [7:0] mem0 [0:4095];
    always @(posedge clk) begin
        if (rdy) begin
            ram_din  <= mem1[ram_a[11:0]];
            ram_din0 <= mem0[ram_a0[11:0]];
            if (ram_wr)  mem1[ram_a[11:0]]  = ram_dout;
            if (ram_wr0) mem0[ram_a0[11:0]] = ram_dout0;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    // Scoreboards
    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          chkd;
    } sb_t;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    sb_t ifq[$];
    sb_t maq[$];
    wr_t wq[$];
    sb_t e_if, e_ma;
    wr_t e_wr;
    int  if_start = 0;
    int  ma_start = 0;

    always @(negedge clk) begin
        if (if_done) begin
            if (ifq.size() == 0) check("if_spurious_done", 32'd1, 32'd0);
            else begin
                e_if = ifq.pop_front();
                check("if_latency", 32'(cyc - if_start), 32'(e_if.lat));
                check("if_inst", if_inst, e_if.data);
            end
        end
        if (ma_done) begin
            if (maq.size() == 0) check("ma_spurious_done", 32'd1, 32'd0);
            else begin
                e_ma = maq.pop_front();
                check("ma_latency", 32'(cyc - ma_start), 32'(e_ma.lat));
                if (e_ma.chkd) check("ma_rdata", ma_rdata, e_ma.data);
            end
        end
        if (ram_wr) begin
            if (wq.size() == 0) check("spurious_write", 32'd1, 32'd0);
            else begin
                e_wr = wq.pop_front();
                check("wr_addr", ram_a, e_wr.addr);
                check("wr_data", {24'd0, ram_dout}, {24'd0, e_wr.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (if_done) seen = 1;
        end
        if (!seen) check("if_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ma_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ma_done) seen = 1;
        end
        if (!seen) check("ma_done_timeout", 32'd0, 32'd1);
    endtask

    // Caller is positioned just after a posedge; this cycle is the request cycle.
    task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp, input int lat);
        ifq.push_back('{data: exp, lat: lat, chkd: 1'b1});
        if_start = cyc;
        if_addr  = addr;
        if_req   = 1'b1;
        wait_if_done();
        step();
        if_req = 1'b0;
    endtask

    task automatic ma_txn(input logic we, input logic [2:0] w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int lat);
        maq.push_back('{data: exp, lat: lat, chkd: !we});
        ma_start = cyc;
        ma_width = w;
        ma_addr  = addr;
        ma_wdata = wdata;
        ma_we    = we;
        ma_re    = !we;
        wait_ma_done();
        step();
        ma_re = 1'b0;
        ma_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ram_a"},    ram_a, 32'd0);
        check({pfx, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
        check({pfx, "_ram_wr"},   {31'd0, ram_wr}, 32'd0);
        check({pfx, "_if_done"},  {31'd0, if_done}, 32'd0);
        check({pfx, "_ma_done"},  {31'd0, ma_done}, 32'd0);
        check({pfx, "_if_inst"},  if_inst, 32'd0);
        check({pfx, "_ma_rdata"}, ma_rdata, 32'd0);
    endtask

    int s0;
    bit seen0;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 8'h00;
            mem0[i] = 8'h00;
        end
        mem1[12'h100] = 8'h13; mem1[12'h101] = 8'h05; mem1[12'h102] = 8'h10; mem1[12'h103] = 8'h00;
        mem1[12'h104] = 8'hEF; mem1[12'h105] = 8'hBE; mem1[12'h106] = 8'hAD; mem1[12'h107] = 8'hDE;
        mem1[12'h200] = 8'h80;
        mem1[12'h300] = 8'h11; mem1[12'h301] = 8'h22; mem1[12'h302] = 8'h33; mem1[12'h303] = 8'h44;
        mem1[12'h500] = 8'h0D; mem1[12'h501] = 8'hF0; mem1[12'h502] = 8'hFE; mem1[12'h503] = 8'hCA;
        for (int i = 0; i < 4; i++) begin
            mem0[12'h100 + i] = mem1[12'h100 + i];
            mem0[12'h500 + i] = mem1[12'h500 + i];
        end

        rst = 1'b0; rdy = 1'b1;
        if_req = 0; if_flush = 0; if_addr = 0;
        ma_re = 0; ma_we = 0; ma_width = 0; ma_addr = 0; ma_wdata = 0;
        if_req0 = 0; ma_re0 = 0; ma_we0 = 0;
        step(); step();
        @(negedge clk);
        check_reset_outputs("por");
        step();
        rst = 1'b1;
        step();

        // IF word fetch with address sequence and stall check
        fork
            if_txn(32'h100, 32'h00100513, 6);
            begin
                @(negedge clk);
                check("if_stall_c0", {31'd0, if_stall_req}, 32'd1);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("if_ram_a", ram_a, 32'h100 + 32'(k));
                end
                @(negedge clk);
                check("if_stall_c5", {31'd0, if_stall_req}, 32'd1);
            end
        join
        step();

        // Signed / unsigned byte loads
        ma_txn(1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFFFF80, 3);
        step();
        ma_txn(1'b0, 3'b100, 32'h200, 32'h0, 32'h00000080, 3);
        step();

        // Half store straddling 0x1FF/0x200, then signed half load back
        wq.push_back('{addr: 32'h1FF, data: 8'hEF});
        wq.push_back('{addr: 32'h200, data: 8'hBE});
        ma_txn(1'b1, 3'b001, 32'h1FF, 32'hDEADBEEF, 32'h0, 3);
        step();
        ma_txn(1'b0, 3'b001, 32'h1FF, 32'h0, 32'hFFFFBEEF, 4);
        step();

        // Word store / load, byte store / unsigned load
        wq.push_back('{addr: 32'h400, data: 8'h78});
        wq.push_back('{addr: 32'h401, data: 8'h56});
        wq.push_back('{addr: 32'h402, data: 8'h34});
        wq.push_back('{addr: 32'h403, data: 8'h12});
        ma_txn(1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0, 5);
        step();
        ma_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 6);
        wq.push_back('{addr: 32'h410, data: 8'hA5});
        ma_txn(1'b1, 3'b000, 32'h410, 32'h000000A5, 32'h0, 2);
        ma_txn(1'b0, 3'b100, 32'h410, 32'h0, 32'h000000A5, 3);
        step();

        // rdy low for 3 cycles mid word load
        fork
            ma_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h44332211, 9);
            begin
                step();
                step();
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rdy_ram_a", ram_a, 32'h301);
                    check("rdy_ram_wr", {31'd0, ram_wr}, 32'd0);
                    step();
                end
                rdy = 1'b1;
            end
        join
        step();

        // Flush in ISSUE cnt=2, redirect to 0x104 in the following cycle
        if_addr = 32'h100;
        if_req  = 1'b1;
        step(); step(); step();
        if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        ifq.push_back('{data: 32'hDEADBEEF, lat: 6, chkd: 1'b1});
        if_start = cyc;
        if_addr  = 32'h104;
        @(negedge clk);
        step();
        @(negedge clk);
        check("redirect_ram_a", ram_a, 32'h104);
        wait_if_done();
        step();
        if_req = 1'b0;
        step();

        // Arbitration, MEM priority: MEM first (6), IF after (13)
        fork
            ma_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 6);
            if_txn(32'h100, 32'h00100513, 13);
        join
        step();

        // Arbitration, IF priority on the second instance
        if_addr = 32'h100; ma_addr = 32'h500; ma_width = 3'b010;
        if_req0 = 1'b1; ma_re0 = 1'b1;
        s0 = cyc;
        seen0 = 0;
        for (int i = 0; i < 60 && !seen0; i++) begin
            @(negedge clk);
            if (if_done0) seen0 = 1;
        end
        check("p0_if_latency", 32'(cyc - s0), 32'd6);
        check("p0_if_inst", if_inst0, 32'h00100513);
        step();
        if_req0 = 1'b0;
        seen0 = 0;
        for (int i = 0; i < 60 && !seen0; i++) begin
            @(negedge clk);
            if (ma_done0) seen0 = 1;
        end
        check("p0_ma_latency", 32'(cyc - s0), 32'd13);
        check("p0_ma_rdata", ma_rdata0, 32'hCAFEF00D);
        step();
        ma_re0 = 1'b0;
        step();

        // Reset in the middle of a word store
        wq.push_back('{addr: 32'h600, data: 8'hD4});
        wq.push_back('{addr: 32'h601, data: 8'hC3});
        ma_width = 3'b010; ma_addr = 32'h600; ma_wdata = 32'hA1B2C3D4;
        ma_we = 1'b1;
        step();
        step();
        rst = 1'b0;
        ma_we = 1'b0;
        step();
        @(negedge clk);
        check_reset_outputs("rst1");
        step();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst2");
        repeat (6) step();

        check("ifq_drained", 32'(ifq.size()), 32'd0);
        check("maq_drained", 32'(maq.size()), 32'd0);
        check("wq_drained",  32'(wq.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
